// File: rtl/player_move_ctrl_pkg.sv
// Shared types, widths and grid defaults for the player movement controller.
package player_move_ctrl_pkg;

    localparam int unsigned GRID_W_DEF = 16;
    localparam int unsigned GRID_H_DEF = 12;
    localparam int unsigned COORD_W    = 4;
    localparam int unsigned TARGET_W   = COORD_W + 1;
    localparam int unsigned PROG_W     = 7;
    localparam int unsigned NUM_DIRS   = 4;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_QUERY = 2'd1,
        ST_CHECK = 2'd2
    } move_state_t;

    // Candidate tile carries one extra high bit so 0-1 and 15+1 land outside the grid instead of wrapping.
    typedef struct packed {
        logic [TARGET_W-1:0] x;
        logic [TARGET_W-1:0] y;
    } target_t;

    function automatic target_t step_target(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input dir_t               dir
    );
        target_t t;
        t.x = {1'b0, x};
        t.y = {1'b0, y};
        case (dir)
            DIR_UP:    t.y = t.y - TARGET_W'(1);
            DIR_DOWN:  t.y = t.y + TARGET_W'(1);
            DIR_LEFT:  t.x = t.x - TARGET_W'(1);
            DIR_RIGHT: t.x = t.x + TARGET_W'(1);
            default:   t = t;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/player_move_ctrl_btn_repeat.sv
// Per-button step generator: a step on the press edge, then auto-repeat while the button stays held.
module player_move_ctrl_btn_repeat #(
    parameter int unsigned REPEAT_DELAY = 20,
    parameter int unsigned REPEAT_RATE  = 6
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic frame_tick_i,
    input  logic btn_i,
    output logic step_o
);

    localparam int unsigned CNT_W = $clog2(REPEAT_DELAY + 1);

    logic             btn_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             fire;

    // After the first repeat the counter is rewound so every later repeat is REPEAT_RATE ticks apart.
    always_comb begin
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + CNT_W'(1);
        fire    = 1'b0;
        if (!btn_i) begin
            cnt_d = '0;
        end else if (frame_tick_i) begin
            if (cnt_inc == CNT_W'(REPEAT_DELAY)) begin
                fire  = 1'b1;
                cnt_d = CNT_W'(REPEAT_DELAY - REPEAT_RATE);
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_q  <= 1'b0;
            cnt_q  <= '0;
            step_o <= 1'b0;
        end else begin
            btn_q  <= btn_i;
            cnt_q  <= cnt_d;
            step_o <= (btn_i & ~btn_q) | fire;
        end
    end

endmodule

// File: rtl/player_move_ctrl.sv
// Turns debounced button levels into tile moves (with map obstacle query), facing, and hold-to-chop progress.
module player_move_ctrl
    import player_move_ctrl_pkg::*;
#(
    parameter int unsigned GRID_W       = GRID_W_DEF,
    parameter int unsigned GRID_H       = GRID_H_DEF,
    parameter int unsigned START_X      = 1,
    parameter int unsigned START_Y      = 1,
    parameter int unsigned REPEAT_DELAY = 20,
    parameter int unsigned REPEAT_RATE  = 6,
    parameter int unsigned CHOP_FRAMES  = 90
) (
    input  logic               clock_in,
    input  logic               reset_in,
    input  logic               frame_tick_in,
    input  logic               up_in,
    input  logic               down_in,
    input  logic               left_in,
    input  logic               right_in,
    input  logic               chop_in,
    input  logic               blocked_in,
    output logic               query_valid,
    output logic [COORD_W-1:0] query_x,
    output logic [COORD_W-1:0] query_y,
    output logic [COORD_W-1:0] player_x,
    output logic [COORD_W-1:0] player_y,
    output logic [1:0]         facing,
    output logic               move_pulse,
    output logic               bump_pulse,
    output logic               chop_active,
    output logic [PROG_W-1:0]  chop_progress,
    output logic               chop_done
);

    localparam logic [TARGET_W-1:0] GRID_W_T  = TARGET_W'(GRID_W);
    localparam logic [TARGET_W-1:0] GRID_H_T  = TARGET_W'(GRID_H);
    localparam logic [PROG_W-1:0]   CHOP_LAST = PROG_W'(CHOP_FRAMES - 1);

    logic [NUM_DIRS-1:0] btn_lvl;
    logic [NUM_DIRS-1:0] step_req;
    logic                any_dir;
    logic                req_valid;
    dir_t                req_dir;
    target_t             target;
    logic                out_of_grid;
    move_state_t         state_q;

    assign btn_lvl = {right_in, left_in, down_in, up_in};
    assign any_dir = |btn_lvl;

    for (genvar i = 0; i < NUM_DIRS; i++) begin : g_dir
        player_move_ctrl_btn_repeat #(
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_repeat (
            .clk_i        (clock_in),
            .rst_i        (reset_in),
            .frame_tick_i (frame_tick_in),
            .btn_i        (btn_lvl[i]),
            .step_o       (step_req[i])
        );
    end

    // Fixed priority UP > DOWN > LEFT > RIGHT; losing requests are simply dropped.
    always_comb begin
        req_valid = 1'b0;
        req_dir   = DIR_UP;
        if (step_req[DIR_UP]) begin
            req_valid = 1'b1;
            req_dir   = DIR_UP;
        end else if (step_req[DIR_DOWN]) begin
            req_valid = 1'b1;
            req_dir   = DIR_DOWN;
        end else if (step_req[DIR_LEFT]) begin
            req_valid = 1'b1;
            req_dir   = DIR_LEFT;
        end else if (step_req[DIR_RIGHT]) begin
            req_valid = 1'b1;
            req_dir   = DIR_RIGHT;
        end
    end

    always_comb begin
        target      = step_target(player_x, player_y, req_dir);
        out_of_grid = (target.x >= GRID_W_T) || (target.y >= GRID_H_T);
    end

    // Move FSM: edge check in IDLE, one-cycle map query, then commit or bump on the map answer.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q     <= ST_IDLE;
            player_x    <= COORD_W'(START_X);
            player_y    <= COORD_W'(START_Y);
            facing      <= DIR_DOWN;
            query_valid <= 1'b0;
            query_x     <= '0;
            query_y     <= '0;
            move_pulse  <= 1'b0;
            bump_pulse  <= 1'b0;
        end else begin
            query_valid <= 1'b0;
            move_pulse  <= 1'b0;
            bump_pulse  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        facing <= req_dir;
                        if (out_of_grid) begin
                            bump_pulse <= 1'b1;
                        end else begin
                            query_x     <= target.x[COORD_W-1:0];
                            query_y     <= target.y[COORD_W-1:0];
                            query_valid <= 1'b1;
                            state_q     <= ST_QUERY;
                        end
                    end
                end
                ST_QUERY: begin
                    state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (blocked_in) begin
                        bump_pulse <= 1'b1;
                    end else begin
                        player_x   <= query_x;
                        player_y   <= query_y;
                        move_pulse <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Chop counter wraps to zero on completion, so progress never reaches CHOP_FRAMES.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            chop_active   <= 1'b0;
            chop_progress <= '0;
            chop_done     <= 1'b0;
        end else begin
            chop_done   <= 1'b0;
            chop_active <= chop_in & ~any_dir;
            if (!chop_in || any_dir) begin
                chop_progress <= '0;
            end else if (frame_tick_in) begin
                if (chop_progress >= CHOP_LAST) begin
                    chop_progress <= '0;
                    chop_done     <= 1'b1;
                end else begin
                    chop_progress <= chop_progress + PROG_W'(1);
                end
            end
        end
    end

endmodule
